cmd_parser: RTL
===============

Name: cmd_parser

Overview:
Front-end command parser that feeds the ALU operand/opcode interface. It receives a framed byte stream on a valid/ready port and assembles opcode, data type and two 16-bit sources. It checks reserved bits and an XOR checksum, then presents the fields with a one-cycle parser_done strobe to the ALU. Malformed, stalled or corrupted frames are dropped, flagged, and never reach the ALU.

Parameters:
TIMEOUT, 256, max idle cycles between accepted bytes inside a frame before abort; 0 disables timeout
CNT_W, 16, width of good-frame counter
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  parser accepts byte this cycle (transfer = in_valid & in_ready)
dtype  output  4  data type field to ALU
operator  output  5  ALU opcode field
src1  output  16  first operand
src2  output  16  second operand
parser_done  output  1  one-cycle strobe: fields valid and new
frame_err  output  1  one-cycle strobe: checksum or reserved-bit failure
timeout_err  output  1  one-cycle strobe: mid-frame stall abort
frame_cnt  output  CNT_W  count of good frames, wraps at 2^CNT_W

Behaviour:
- Frame, 8 bytes: B0=SYNC_BYTE, B1={3'b000,operator}, B2={4'h0,dtype}, B3=src1[15:8], B4=src1[7:0], B5=src2[15:8], B6=src2[7:0], B7=B1^B2^B3^B4^B5^B6.
- Reset: state IDLE; all outputs 0 except in_ready=1; shadow registers, reserved flag and timeout counter cleared. Reset mid-frame discards the partial frame with no error strobe.
- States: IDLE→OP→DTYPE→S1H→S1L→S2H→S2L→CSUM→DONE→IDLE. Each transition occurs only on an accepted byte, except CSUM→DONE/IDLE, DONE→IDLE and timeout.
- IDLE: bytes ≠ SYNC_BYTE are consumed and discarded silently. SYNC_BYTE → OP, clears running checksum and reserved flag.
- OP..S2L: byte stored in shadow register and XORed into the running checksum. Nonzero reserved bits (B1[7:5], B2[7:4]) set the reserved flag; parsing continues.
- CSUM: on accept, if byte == running checksum and reserved flag clear → DONE. Otherwise frame_err=1 the next cycle, → IDLE, outputs unchanged.
- DONE, one cycle: dtype/operator/src1/src2 loaded from shadow registers; parser_done=1; frame_cnt+1; in_ready=0.
- Latency: parser_done and new fields are visible in the cycle after the B7 transfer. Fields hold until the next good frame, so downstream always sees stable values.
- in_ready=1 in every state except DONE. Back-to-back frames lose exactly one cycle.
- Timeout: counter clears on every accepted byte and on entry to OP. It increments each cycle in OP..CSUM without a transfer. When it reaches TIMEOUT (TIMEOUT>0): timeout_err=1 for one cycle, → IDLE, partial frame discarded.
- A SYNC_BYTE value mid-frame is ordinary data; no resync.
- Simultaneous: a transfer in the timeout cycle is ignored (timeout wins). frame_err, timeout_err and parser_done are mutually exclusive.
- frame_cnt wraps from all-ones to 0.

Test Plan:
- Good frame A5 00 01 12 34 00 FF D8 → one cycle after D8: parser_done=1 for 1 cycle, operator=0, dtype=1, src1=0x1234, src2=0x00FF, frame_cnt=1.
- Same frame with checksum D9 → frame_err=1 for 1 cycle; parser_done stays 0; outputs keep prior values; frame_cnt unchanged.
- Leading junk 00 11 FF, then good frame → junk ignored without error strobes; good frame parsed; parser_done strobes once.
- TIMEOUT=16: A5 03, then in_valid low for 16 cycles → timeout_err pulse, state IDLE. A following good frame parses correctly.
- B1=0x25 with a correct checksum → frame_err; operator not updated.
- Two frames back-to-back with in_valid held high → in_ready low exactly one cycle between them; two parser_done strobes; frame_cnt=2. Assert rst mid-frame during a third frame → outputs 0, no strobes.

Source files
------------

// File: rtl/cmd_parser.sv
// Framed byte-stream command parser: assembles opcode, data type and two 16-bit operands,
// validates reserved bits and XOR checksum, and strobes parser_done toward the ALU.
module cmd_parser #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_W     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       dtype,
  output logic [4:0]       operator,
  output logic [15:0]      src1,
  output logic [15:0]      src2,
  output logic             parser_done,
  output logic             frame_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    StIdle, StOp, StDtype, StS1h, StS1l, StS2h, StS2l, StCsum, StDone
  } state_e;

  state_e           r_state;
  logic [4:0]       r_op_sh;
  logic [3:0]       r_dt_sh;
  logic [15:0]      r_s1_sh;
  logic [15:0]      r_s2_sh;
  logic [7:0]       r_csum;
  logic             r_rsv;
  logic [TW-1:0]    r_tmo;
  logic             r_ready;
  logic             r_done;
  logic             r_ferr;
  logic             r_terr;
  logic [3:0]       r_dtype;
  logic [4:0]       r_operator;
  logic [15:0]      r_src1;
  logic [15:0]      r_src2;
  logic [CNT_W-1:0] r_cnt;

  logic       w_xfer;
  logic       w_in_frame;
  logic       w_tmo_hit;
  logic [7:0] w_csum_nxt;

  assign w_xfer     = in_valid & r_ready;
  assign w_in_frame = (r_state != StIdle) && (r_state != StDone);
  // A transfer in the same cycle as the timeout is deliberately dropped.
  assign w_tmo_hit  = (TIMEOUT != 0) && w_in_frame && (r_tmo == TMO_MAX);
  assign w_csum_nxt = r_csum ^ in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_op_sh    <= '0;
      r_dt_sh    <= '0;
      r_s1_sh    <= '0;
      r_s2_sh    <= '0;
      r_csum     <= '0;
      r_rsv      <= 1'b0;
      r_tmo      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_terr     <= 1'b0;
      r_dtype    <= '0;
      r_operator <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_terr <= 1'b0;
      if (w_tmo_hit) begin
        r_terr  <= 1'b1;
        r_state <= StIdle;
        r_tmo   <= '0;
      end else begin
        if (w_in_frame) begin
          r_tmo <= w_xfer ? '0 : ((TIMEOUT != 0) ? r_tmo + 1'b1 : r_tmo);
        end
        case (r_state)
          StIdle: begin
            if (w_xfer && (in_data == SYNC_BYTE)) begin
              r_state <= StOp;
              r_csum  <= '0;
              r_rsv   <= 1'b0;
              r_tmo   <= '0;
            end
          end
          StOp: begin
            if (w_xfer) begin
              r_op_sh <= in_data[4:0];
              r_rsv   <= r_rsv | (|in_data[7:5]);
              r_csum  <= w_csum_nxt;
              r_state <= StDtype;
            end
          end
          StDtype: begin
            if (w_xfer) begin
              r_dt_sh <= in_data[3:0];
              r_rsv   <= r_rsv | (|in_data[7:4]);
              r_csum  <= w_csum_nxt;
              r_state <= StS1h;
            end
          end
          StS1h: begin
            if (w_xfer) begin
              r_s1_sh[15:8] <= in_data;
              r_csum        <= w_csum_nxt;
              r_state       <= StS1l;
            end
          end
          StS1l: begin
            if (w_xfer) begin
              r_s1_sh[7:0] <= in_data;
              r_csum       <= w_csum_nxt;
              r_state      <= StS2h;
            end
          end
          StS2h: begin
            if (w_xfer) begin
              r_s2_sh[15:8] <= in_data;
              r_csum        <= w_csum_nxt;
              r_state       <= StS2l;
            end
          end
          StS2l: begin
            if (w_xfer) begin
              r_s2_sh[7:0] <= in_data;
              r_csum       <= w_csum_nxt;
              r_state      <= StCsum;
            end
          end
          StCsum: begin
            if (w_xfer) begin
              if ((in_data == r_csum) && !r_rsv) begin
                r_state    <= StDone;
                r_ready    <= 1'b0;
                r_done     <= 1'b1;
                r_dtype    <= r_dt_sh;
                r_operator <= r_op_sh;
                r_src1     <= r_s1_sh;
                r_src2     <= r_s2_sh;
                r_cnt      <= r_cnt + 1'b1;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= StIdle;
              end
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready    = r_ready;
  assign dtype       = r_dtype;
  assign operator    = r_operator;
  assign src1        = r_src1;
  assign src2        = r_src2;
  assign parser_done = r_done;
  assign frame_err   = r_ferr;
  assign timeout_err = r_terr;
  assign frame_cnt   = r_cnt;

endmodule
